tl_rx_fc_credit_allocator: RTL
==============================

Name: tl_rx_fc_credit_allocator

Overview:
Receive-side flow-control credit allocator for the TL RX path. Keeps per-type CREDITS_ALLOCATED counters for Posted, Non-Posted and Completion traffic. The counters start from the receive buffer capacities and grow as the RX buffers free space. The counter and scale values drive the credit/scale register inputs of the downstream flow-control error checker. The block also sequences InitFC and UpdateFC requests to the DLL through a valid/ready handshake.

Parameters:
FC_DATA_CREDS_WIDTH, 16, data credit counter width
FC_HDR_CREDS_WIDTH, 12, header credit counter width
REL_DATA_WIDTH, 8, width of the per-release data credit amount
P_HDR_CAP / NP_HDR_CAP / CPL_HDR_CAP, 64 / 32 / 0, initial header credits per type; 0 = infinite
P_DATA_CAP / NP_DATA_CAP / CPL_DATA_CAP, 512 / 32 / 0, initial data credits per type; 0 = infinite
HDR_SCALE / DATA_SCALE, 2'b01 / 2'b01, static scale values for all types
UPDATE_PERIOD, 1024, refresh timer period in cycles (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
link_up  in  1  DLL link-up; low forces re-initialisation
rel_valid  in  1  buffer release strobe, one release per cycle
rel_typ  in  2  00 P, 01 NP, 10 CPL, 11 ignored
rel_hdr  in  4  header credits freed
rel_data  in  REL_DATA_WIDTH  data credits freed
fc_req_valid  out  1  FC DLLP request valid
fc_req_ready  in  1  DLL accepts request
fc_req_init  out  1  1 = InitFC, 0 = UpdateFC
fc_req_typ  out  2  type of the request
fc_req_hdr_creds  out  FC_HDR_CREDS_WIDTH  advertised header credits
fc_req_data_creds  out  FC_DATA_CREDS_WIDTH  advertised data credits
fc_active  out  1  initialisation complete
p/np/cpl_hdr_creds_reg  out  FC_HDR_CREDS_WIDTH each  allocated header credits
p/np/cpl_data_creds_reg  out  FC_DATA_CREDS_WIDTH each  allocated data credits
p/np/cpl_hdr_scale_reg, p/np/cpl_data_scale_reg  out  2 each  HDR_SCALE / DATA_SCALE constants

Behaviour:
- Reset, or link_up low: FSM goes to S_IDLE. Counters load the *_CAP values. fc_req_valid=0, fc_req_init=0, fc_req_typ=0, request credit fields=0, fc_active=0, pending bits=0.
- S_IDLE: when link_up=1, go to S_INIT_P next cycle.
- S_INIT_P, S_INIT_NP, S_INIT_CPL:
  - fc_req_valid=1, fc_req_init=1, fc_req_typ set to the state's type, credit fields = that type's counters.
  - Advance on the fc_req_valid & fc_req_ready cycle. After S_INIT_CPL, go to S_ACTIVE and set fc_active=1 from the next cycle.
- Counter update: on rel_valid with a finite-capacity type, hdr += rel_hdr and data += rel_data (zero-extended), both modulo 2^width; wrap-around is legal.
  - Infinite-capacity counters stay 0 and ignore releases. rel_typ=11 is ignored.
  - Releases during the INIT states update counters but set no pending bit.
- Pending: in S_ACTIVE, a release to a finite type sets pend[typ].
- Request issue in S_ACTIVE, when no request is outstanding:
  - Pick the highest-priority pending type: P > NP > CPL.
  - Register the request; fc_req_valid goes high on the next cycle.
  - Credit fields are captured at issue and held stable until accepted.
- Acceptance: on handshake, clear pend[typ] and drop valid. A release to the same type in the acceptance cycle re-sets pend[typ], because those credits were not in the captured value.
- While fc_req_valid=1 and ready=0, all outputs hold.
- link_up falling mid-request: drop valid immediately and go to S_IDLE.
- *_creds_reg outputs are the live counters, updated one cycle after rel_valid.

Optional Feature:
TL_RX_FC_UPDATE_TIMER_EN:
- Defined: a free-running counter runs in S_ACTIVE. When it reaches UPDATE_PERIOD-1 it wraps to 0 and sets pend for every finite-capacity type, giving a periodic refresh. It resets on each entry to S_ACTIVE.
- Undefined: no timer; UpdateFC is sent only after releases.

Test Plan:
- Reset, link_up=1, ready=1 -> three InitFC requests in order P(64,512), NP(32,32), CPL(0,0); fc_active=1 afterwards.
- ACTIVE, release P hdr=1 data=16 -> p_hdr_creds_reg=65, p_data_creds_reg=528; UpdateFC P(65,528).
- Simultaneous pend P and NP, ready=0 for 5 cycles -> P request held stable, then NP issued after P accepted.
- Release P in the accept cycle of the P update -> second UpdateFC P carries the newer value.
- p_data at 65530, release data=10 -> wraps to 4; CPL release -> counters stay 0, no request.
- link_up low mid-request -> fc_req_valid=0 next cycle, counters back to CAP values, InitFC sequence restarts when link_up returns high.

Source files
------------

// File: rtl/tl_rx_fc_credit_allocator_if.sv
// rtl/tl_rx_fc_credit_allocator_if.sv - FC DLLP request handshake between the RX credit allocator and the DLL
interface tl_rx_fc_credit_allocator_if #(
    parameter int HDR_W  = 12,
    parameter int DATA_W = 16
);
    logic              fc_req_valid;
    logic              fc_req_ready;
    logic              fc_req_init;
    logic [1:0]        fc_req_typ;
    logic [HDR_W-1:0]  fc_req_hdr_creds;
    logic [DATA_W-1:0] fc_req_data_creds;

    modport master (
        output fc_req_valid,
        output fc_req_init,
        output fc_req_typ,
        output fc_req_hdr_creds,
        output fc_req_data_creds,
        input  fc_req_ready
    );

    modport slave (
        input  fc_req_valid,
        input  fc_req_init,
        input  fc_req_typ,
        input  fc_req_hdr_creds,
        input  fc_req_data_creds,
        output fc_req_ready
    );
endinterface

// File: rtl/tl_rx_fc_credit_allocator.sv
// rtl/tl_rx_fc_credit_allocator.sv - RX flow-control credit allocator; TL_RX_FC_UPDATE_TIMER_EN adds periodic UpdateFC refresh
module tl_rx_fc_credit_allocator #(
    parameter int         FC_DATA_CREDS_WIDTH = 16,
    parameter int         FC_HDR_CREDS_WIDTH  = 12,
    parameter int         REL_DATA_WIDTH      = 8,
    parameter int         P_HDR_CAP           = 64,
    parameter int         NP_HDR_CAP          = 32,
    parameter int         CPL_HDR_CAP         = 0,
    parameter int         P_DATA_CAP          = 512,
    parameter int         NP_DATA_CAP         = 32,
    parameter int         CPL_DATA_CAP        = 0,
    parameter logic [1:0] HDR_SCALE           = 2'b01,
    parameter logic [1:0] DATA_SCALE          = 2'b01,
    parameter int         UPDATE_PERIOD       = 1024
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            link_up,
    input  logic                            rel_valid,
    input  logic [1:0]                      rel_typ,
    input  logic [3:0]                      rel_hdr,
    input  logic [REL_DATA_WIDTH-1:0]       rel_data,
    tl_rx_fc_credit_allocator_if.master     fc_req,
    output logic                            fc_active,
    output logic [FC_HDR_CREDS_WIDTH-1:0]   p_hdr_creds_reg,
    output logic [FC_HDR_CREDS_WIDTH-1:0]   np_hdr_creds_reg,
    output logic [FC_HDR_CREDS_WIDTH-1:0]   cpl_hdr_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0]  p_data_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0]  np_data_creds_reg,
    output logic [FC_DATA_CREDS_WIDTH-1:0]  cpl_data_creds_reg,
    output logic [1:0]                      p_hdr_scale_reg,
    output logic [1:0]                      np_hdr_scale_reg,
    output logic [1:0]                      cpl_hdr_scale_reg,
    output logic [1:0]                      p_data_scale_reg,
    output logic [1:0]                      np_data_scale_reg,
    output logic [1:0]                      cpl_data_scale_reg
);
    localparam int HW = FC_HDR_CREDS_WIDTH;
    localparam int DW = FC_DATA_CREDS_WIDTH;

    localparam logic [HW-1:0] HDR_CAP  [3] = '{HW'(P_HDR_CAP), HW'(NP_HDR_CAP), HW'(CPL_HDR_CAP)};
    localparam logic [DW-1:0] DATA_CAP [3] = '{DW'(P_DATA_CAP), DW'(NP_DATA_CAP), DW'(CPL_DATA_CAP)};
    // A type is finite (and can request UpdateFC) if either of its counters is finite
    localparam logic [2:0] TYPE_FIN = {(CPL_HDR_CAP != 0) || (CPL_DATA_CAP != 0),
                                       (NP_HDR_CAP != 0)  || (NP_DATA_CAP != 0),
                                       (P_HDR_CAP != 0)   || (P_DATA_CAP != 0)};

    typedef enum logic [2:0] {S_IDLE, S_INIT_P, S_INIT_NP, S_INIT_CPL, S_ACTIVE} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] hdr_cnt  [3];
    logic [HW-1:0] hdr_nxt  [3];
    logic [DW-1:0] data_cnt [3];
    logic [DW-1:0] data_nxt [3];
    logic [2:0]    pend, pend_nxt;
    logic          accept, load_req, load_init, drop_req, tick;
    logic [1:0]    load_typ;

    assign accept = fc_req.fc_req_valid & fc_req.fc_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        load_init = 1'b0;
        load_typ  = 2'd0;
        drop_req  = 1'b0;
        case (state)
            S_IDLE: if (link_up) begin
                state_nxt = S_INIT_P;
                load_req  = 1'b1;
                load_init = 1'b1;
                load_typ  = 2'd0;
            end
            S_INIT_P: if (accept) begin
                state_nxt = S_INIT_NP;
                load_req  = 1'b1;
                load_init = 1'b1;
                load_typ  = 2'd1;
            end
            S_INIT_NP: if (accept) begin
                state_nxt = S_INIT_CPL;
                load_req  = 1'b1;
                load_init = 1'b1;
                load_typ  = 2'd2;
            end
            S_INIT_CPL: if (accept) begin
                state_nxt = S_ACTIVE;
                drop_req  = 1'b1;
            end
            S_ACTIVE: begin
                if (accept) begin
                    drop_req = 1'b1;
                end else if (!fc_req.fc_req_valid && (pend != 3'b000)) begin
                    load_req = 1'b1;
                    if (pend[0])      load_typ = 2'd0;
                    else if (pend[1]) load_typ = 2'd1;
                    else              load_typ = 2'd2;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!link_up) begin
            state_nxt = S_IDLE;
            load_req  = 1'b0;
            drop_req  = 1'b0;
        end
    end

    // Infinite-capacity counters never move off zero; width truncation gives the legal wrap
    always_comb begin
        for (int t = 0; t < 3; t++) begin
            hdr_nxt[t]  = hdr_cnt[t];
            data_nxt[t] = data_cnt[t];
            if (!link_up) begin
                hdr_nxt[t]  = HDR_CAP[t];
                data_nxt[t] = DATA_CAP[t];
            end else if (rel_valid && (rel_typ == 2'(t))) begin
                if (HDR_CAP[t] != '0)  hdr_nxt[t]  = hdr_cnt[t] + HW'(rel_hdr);
                if (DATA_CAP[t] != '0) data_nxt[t] = data_cnt[t] + DW'(rel_data);
            end
        end
    end

    // A release in the accept cycle re-sets pend: it is not in the captured value
    always_comb begin
        pend_nxt = pend;
        if (state == S_ACTIVE) begin
            if (accept) pend_nxt[fc_req.fc_req_typ] = 1'b0;
            for (int t = 0; t < 3; t++) begin
                if (rel_valid && (rel_typ == 2'(t)) && TYPE_FIN[t]) pend_nxt[t] = 1'b1;
            end
            if (tick) pend_nxt = pend_nxt | TYPE_FIN;
        end
        if (!link_up) pend_nxt = 3'b000;
    end

`ifdef TL_RX_FC_UPDATE_TIMER_EN
    localparam int TW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    logic [TW-1:0] tmr;

    assign tick = (state == S_ACTIVE) && (tmr == TW'(UPDATE_PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            tmr <= '0;
        else if ((state != S_ACTIVE) || tick) tmr <= '0;
        else                                tmr <= tmr + 1'b1;
    end
`else
    assign tick = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < 3; t++) begin
                hdr_cnt[t]  <= HDR_CAP[t];
                data_cnt[t] <= DATA_CAP[t];
            end
            pend                     <= 3'b000;
            fc_active                <= 1'b0;
            fc_req.fc_req_valid      <= 1'b0;
            fc_req.fc_req_init       <= 1'b0;
            fc_req.fc_req_typ        <= 2'd0;
            fc_req.fc_req_hdr_creds  <= '0;
            fc_req.fc_req_data_creds <= '0;
        end else begin
            for (int t = 0; t < 3; t++) begin
                hdr_cnt[t]  <= hdr_nxt[t];
                data_cnt[t] <= data_nxt[t];
            end
            pend      <= pend_nxt;
            fc_active <= (state_nxt == S_ACTIVE);
            if (!link_up) begin
                fc_req.fc_req_valid      <= 1'b0;
                fc_req.fc_req_init       <= 1'b0;
                fc_req.fc_req_typ        <= 2'd0;
                fc_req.fc_req_hdr_creds  <= '0;
                fc_req.fc_req_data_creds <= '0;
            end else if (load_req) begin
                fc_req.fc_req_valid      <= 1'b1;
                fc_req.fc_req_init       <= load_init;
                fc_req.fc_req_typ        <= load_typ;
                fc_req.fc_req_hdr_creds  <= hdr_nxt[load_typ];
                fc_req.fc_req_data_creds <= data_nxt[load_typ];
            end else if (drop_req) begin
                fc_req.fc_req_valid      <= 1'b0;
                fc_req.fc_req_init       <= 1'b0;
            end
        end
    end

    assign p_hdr_creds_reg    = hdr_cnt[0];
    assign np_hdr_creds_reg   = hdr_cnt[1];
    assign cpl_hdr_creds_reg  = hdr_cnt[2];
    assign p_data_creds_reg   = data_cnt[0];
    assign np_data_creds_reg  = data_cnt[1];
    assign cpl_data_creds_reg = data_cnt[2];

    assign p_hdr_scale_reg    = HDR_SCALE;
    assign np_hdr_scale_reg   = HDR_SCALE;
    assign cpl_hdr_scale_reg  = HDR_SCALE;
    assign p_data_scale_reg   = DATA_SCALE;
    assign np_data_scale_reg  = DATA_SCALE;
    assign cpl_data_scale_reg = DATA_SCALE;
endmodule
